// File: rtl/capture_readout_controller.sv
`default_nettype none
// ============================================================================
// Module      : capture_readout_controller
// Description : Read side of the logic-analyzer capture buffer. When a
//               capture stops it snapshots the writer's waddr/primed state,
//               walks the buffer oldest-to-newest issuing one read per
//               sample, and presents each sample on a valid/ready stream.
//               Handles wrapped (primed) and partially filled buffers.
// Ports       : clk, reset      - clock, synchronous active-high reset
//               start           - capture finished, begin readout (IDLE only)
//               waddr_in        - writer's next write address at stop
//               primed_in       - writer has wrapped at least once
//               raddr, rd_en    - buffer read port (rdata valid next cycle)
//               rdata           - buffer read data
//               out_data/valid/ready/last - sample stream to consumer
//               busy            - readout in progress
//               done            - one-cycle pulse when readout completes
// Revision    : 1.0 - initial release
// ============================================================================
module capture_readout_controller #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] waddr_in,
    input  logic                  primed_in,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        FETCH   = 3'd2,
        PRESENT = 3'd3,
        FINISH  = 3'd4
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] raddr_q;
    logic [ADDR_WIDTH:0]   remaining_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_valid_q;
    logic                  out_last_q;

    // Snapshot values taken from the writer on start.
    logic [ADDR_WIDTH-1:0] snap_raddr;
    logic [ADDR_WIDTH:0]   snap_remaining;

    always_comb begin
        snap_raddr     = ADDR_WIDTH'(1);
        snap_remaining = '0;
        if (primed_in) begin
            // Buffer has wrapped: the next write slot holds the oldest sample.
            snap_raddr     = waddr_in;
            snap_remaining = {1'b1, {ADDR_WIDTH{1'b0}}};
        end else begin
            // Writer starts at address 1 after reset, so 1..waddr_in-1 is valid.
            snap_raddr     = ADDR_WIDTH'(1);
            snap_remaining = {1'b0, waddr_in - ADDR_WIDTH'(1)};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            raddr_q     <= '0;
            remaining_q <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        raddr_q     <= snap_raddr;
                        remaining_q <= snap_remaining;
                        // An empty unprimed buffer completes with no reads.
                        state_q     <= (snap_remaining == '0) ? FINISH : ISSUE;
                    end
                end
                ISSUE: begin
                    state_q <= FETCH;
                end
                FETCH: begin
                    out_data_q  <= rdata;
                    out_valid_q <= 1'b1;
                    out_last_q  <= (remaining_q == (ADDR_WIDTH+1)'(1));
                    raddr_q     <= raddr_q + ADDR_WIDTH'(1);
                    remaining_q <= remaining_q - (ADDR_WIDTH+1)'(1);
                    state_q     <= PRESENT;
                end
                PRESENT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        state_q     <= out_last_q ? FINISH : ISSUE;
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign raddr     = raddr_q;
    assign rd_en     = (state_q == ISSUE);
    assign done      = (state_q == FINISH);
    assign busy      = (state_q != IDLE);
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

endmodule
`default_nettype wire
